// File: rtl/lmc_pkg.sv
// rtl/lmc_pkg.sv - shared opcodes, mux selects, strobe indices and state encoding for the LMC sequencer
package lmc_pkg;

   localparam int OP_HLT = 0;
   localparam int OP_ADD = 1;
   localparam int OP_SUB = 2;
   localparam int OP_STA = 3;
   localparam int OP_LDA = 4;
   localparam int OP_BRA = 5;
   localparam int OP_BRZ = 6;
   localparam int OP_BRP = 7;
   localparam int OP_INP = 8;
   localparam int OP_OUT = 9;

   localparam logic [1:0] MUX_IN  = 2'b00;
   localparam logic [1:0] MUX_SUM = 2'b01;
   localparam logic [1:0] MUX_SUB = 2'b10;
   localparam logic [1:0] MUX_RAM = 2'b11;

   // Bit positions inside strobe_onehot; timer555 is owned by ADVANCE, not by the opcode.
   localparam int STB_W     = 6;
   localparam int STB_ACC   = 0;
   localparam int STB_RAM   = 1;
   localparam int STB_OUT   = 2;
   localparam int STB_JMP   = 3;
   localparam int STB_ZJMP  = 4;
   localparam int STB_PZJMP = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_WAIT_IN,
      ST_ADVANCE,
      ST_HALT
   } state_t;

   typedef struct packed {
      logic [1:0]       mux_sel;
      logic             mux_en;
      logic [STB_W-1:0] strobe_onehot;
      logic             is_branch;
      logic             is_inp;
      logic             is_hlt;
   } decode_t;

endpackage

// File: rtl/lmc_opcode_decode.sv
// rtl/lmc_opcode_decode.sv - combinational opcode decoder: mux select, strobe one-hot and class flags
module lmc_opcode_decode
   import lmc_pkg::*;
#(
   parameter int OPC_W = 4
) (
   input  logic [OPC_W-1:0] opcode,
   output decode_t          dec
);

   always_comb begin
      dec = '0;
      case (int'(opcode))
         OP_HLT: dec.is_hlt = 1'b1;
         OP_ADD: begin
            dec.mux_en                 = 1'b1;
            dec.mux_sel                = MUX_SUM;
            dec.strobe_onehot[STB_ACC] = 1'b1;
         end
         OP_SUB: begin
            dec.mux_en                 = 1'b1;
            dec.mux_sel                = MUX_SUB;
            dec.strobe_onehot[STB_ACC] = 1'b1;
         end
         OP_STA: dec.strobe_onehot[STB_RAM] = 1'b1;
         OP_LDA: begin
            dec.mux_en                 = 1'b1;
            dec.mux_sel                = MUX_RAM;
            dec.strobe_onehot[STB_ACC] = 1'b1;
         end
         OP_BRA: begin
            dec.is_branch              = 1'b1;
            dec.strobe_onehot[STB_JMP] = 1'b1;
         end
         OP_BRZ: begin
            dec.is_branch               = 1'b1;
            dec.strobe_onehot[STB_ZJMP] = 1'b1;
         end
         OP_BRP: begin
            dec.is_branch                = 1'b1;
            dec.strobe_onehot[STB_PZJMP] = 1'b1;
         end
         // INP's Acc strobe is issued from WAIT_IN once the operand arrives.
         OP_INP: begin
            dec.mux_en                 = 1'b1;
            dec.mux_sel                = MUX_IN;
            dec.is_inp                 = 1'b1;
            dec.strobe_onehot[STB_ACC] = 1'b1;
         end
         OP_OUT: dec.strobe_onehot[STB_OUT] = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/lmc_control_unit.sv
// rtl/lmc_control_unit.sv - fixed 4-cycle fetch/decode/exec/advance sequencer driving the LMC datapath strobes
module lmc_control_unit
   import lmc_pkg::*;
#(
   parameter int OPC_W = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             step,
   input  logic [OPC_W-1:0] instr,
   input  logic             Z_flag,
   input  logic             PZ_flag,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [1:0]       MUX_switch,
   output logic             Acc_button,
   output logic             RAM_button,
   output logic             Output_button,
   output logic             timer555,
   output logic             JMP,
   output logic             Z_JMP,
   output logic             PZ_JMP,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count
);

   state_t           state;
   state_t           state_nxt;
   logic [OPC_W-1:0] opcode_q;
   logic [1:0]       mux_q;
   logic             z_q;
   logic             pz_q;
   logic             step_mode_q;
   logic [STB_W-1:0] strobes;
   logic             taken;
   logic             retire;
   decode_t          dec;

   lmc_opcode_decode #(.OPC_W(OPC_W)) u_decode (
      .opcode (opcode_q),
      .dec    (dec)
   );

   // Branch outcome uses only the flags captured in DECODE.
   assign taken = dec.is_branch &&
                  (dec.strobe_onehot[STB_JMP] ||
                   (dec.strobe_onehot[STB_ZJMP]  && z_q) ||
                   (dec.strobe_onehot[STB_PZJMP] && pz_q));

   assign retire = (state == ST_ADVANCE) || (state == ST_DECODE && dec.is_hlt);

   assign MUX_switch = (state == ST_DECODE && dec.mux_en) ? dec.mux_sel : mux_q;

   always_comb begin
      state_nxt = state;
      strobes   = '0;
      timer555  = 1'b0;
      in_ready  = 1'b0;
      halted    = 1'b0;
      case (state)
         ST_IDLE:   if (run || step) state_nxt = ST_FETCH;
         ST_FETCH:  state_nxt = ST_DECODE;
         ST_DECODE: begin
            if (dec.is_hlt)      state_nxt = ST_HALT;
            else if (dec.is_inp) state_nxt = ST_WAIT_IN;
            else                 state_nxt = ST_EXEC;
         end
         ST_EXEC: begin
            strobes   = dec.strobe_onehot;
            state_nxt = ST_ADVANCE;
         end
         ST_WAIT_IN: begin
            if (in_valid) begin
               in_ready         = 1'b1;
               strobes[STB_ACC] = 1'b1;
               state_nxt        = ST_ADVANCE;
            end
         end
         ST_ADVANCE: begin
            timer555  = !taken;
            state_nxt = (run && !step_mode_q) ? ST_FETCH : ST_IDLE;
         end
         ST_HALT:   halted = 1'b1;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   assign Acc_button    = strobes[STB_ACC];
   assign RAM_button    = strobes[STB_RAM];
   assign Output_button = strobes[STB_OUT];
   assign JMP           = strobes[STB_JMP];
   assign Z_JMP         = strobes[STB_ZJMP];
   assign PZ_JMP        = strobes[STB_PZJMP];

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         opcode_q    <= '0;
         mux_q       <= MUX_IN;
         z_q         <= 1'b0;
         pz_q        <= 1'b0;
         step_mode_q <= 1'b0;
         instr_count <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && (run || step))
            step_mode_q <= step && !run;
         if (state == ST_FETCH)
            opcode_q <= instr;
         if (state == ST_DECODE) begin
            z_q  <= Z_flag;
            pz_q <= PZ_flag;
            if (dec.mux_en)
               mux_q <= dec.mux_sel;
         end
         if (retire && instr_count != '1)
            instr_count <= instr_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_lmc_control_unit.sv
// tb/tb_lmc_control_unit.sv - table-driven and scoreboard bench for lmc_control_unit
module tb_lmc_control_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic       run;
   logic       step;
   logic [3:0] instr;
   logic       Z_flag;
   logic       PZ_flag;
   logic       in_valid;

   logic       in_ready, Acc_button, RAM_button, Output_button, timer555, JMP, Z_JMP, PZ_JMP, halted;
   logic [1:0] MUX_switch;
   logic [7:0] instr_count;

   logic       in_ready2, Acc_button2, RAM_button2, Output_button2, timer5552, JMP2, Z_JMP2, PZ_JMP2, halted2;
   logic [1:0] MUX_switch2;
   logic [1:0] instr_count2;

   lmc_control_unit #(.OPC_W(4), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .run(run), .step(step), .instr(instr),
      .Z_flag(Z_flag), .PZ_flag(PZ_flag), .in_valid(in_valid), .in_ready(in_ready),
      .MUX_switch(MUX_switch), .Acc_button(Acc_button), .RAM_button(RAM_button),
      .Output_button(Output_button), .timer555(timer555), .JMP(JMP), .Z_JMP(Z_JMP),
      .PZ_JMP(PZ_JMP), .halted(halted), .instr_count(instr_count)
   );

   lmc_control_unit #(.OPC_W(4), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .run(run), .step(step), .instr(instr),
      .Z_flag(Z_flag), .PZ_flag(PZ_flag), .in_valid(in_valid), .in_ready(in_ready2),
      .MUX_switch(MUX_switch2), .Acc_button(Acc_button2), .RAM_button(RAM_button2),
      .Output_button(Output_button2), .timer555(timer5552), .JMP(JMP2), .Z_JMP(Z_JMP2),
      .PZ_JMP(PZ_JMP2), .halted(halted2), .instr_count(instr_count2)
   );

   always #5 clk = ~clk;

   // Observed word: {in_ready, Acc, RAM, Out, timer555, JMP, Z_JMP, PZ_JMP, halted, MUX[1:0]}
   typedef struct {
      logic [10:0] w;
      string       tag;
   } exp_t;

   typedef struct packed {
      logic [3:0] op;
      logic       z;
      logic       pz;
      logic       iv;
      logic       flip;
      logic [1:0] mux;
      logic [6:0] stb;  // {in_ready, acc, ram, out, jmp, zjmp, pzjmp}
      logic       tmr;
   } vec_t;

   localparam logic [6:0] S_NONE = 7'b0000000;
   localparam logic [6:0] S_ACC  = 7'b0100000;
   localparam logic [6:0] S_RAM  = 7'b0010000;
   localparam logic [6:0] S_OUT  = 7'b0001000;
   localparam logic [6:0] S_JMP  = 7'b0000100;
   localparam logic [6:0] S_ZJ   = 7'b0000010;
   localparam logic [6:0] S_PZJ  = 7'b0000001;
   localparam logic [6:0] S_INP  = 7'b1100000;
   localparam logic [10:0] W_HALT = 11'b00000000100;

   exp_t       q[$];
   vec_t       tbl[0:18];
   int         n_vec = 0;
   int         n_err = 0;
   int         exp_cnt = 0;
   logic [1:0] cur_mux = 2'b00;

   function automatic logic [10:0] act_word();
      return {in_ready, Acc_button, RAM_button, Output_button, timer555,
              JMP, Z_JMP, PZ_JMP, halted, MUX_switch};
   endfunction

   function automatic logic [10:0] exec_word(input logic [6:0] stb, input logic [1:0] mux);
      return {stb[6:3], 1'b0, stb[2:0], 1'b0, mux};
   endfunction

   function automatic logic [10:0] adv_word(input logic tmr, input logic [1:0] mux);
      return {4'b0000, tmr, 3'b000, 1'b0, mux};
   endfunction

   function automatic logic [10:0] quiet_word(input logic [1:0] mux);
      return {9'b0, mux};
   endfunction

   task automatic push(input logic [10:0] w, input string tag);
      exp_t e;
      e.w   = w;
      e.tag = tag;
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         logic [10:0] a;
         e = q.pop_front();
         a = act_word();
         n_vec++;
         if (a !== e.w) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", e.tag, a, e.w);
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Entered at posedge+1 with the sequencer in IDLE; leaves the same way.
   task automatic do_vec(input vec_t v, input int idx);
      instr    = v.op;
      Z_flag   = v.z;
      PZ_flag  = v.pz;
      in_valid = v.iv;
      step     = 1'b1;
      @(posedge clk); #1;
      step = 1'b0;
      push(quiet_word(cur_mux),         $sformatf("v%0d_fetch", idx));
      push(quiet_word(v.mux),           $sformatf("v%0d_decode", idx));
      push(exec_word(v.stb, v.mux),     $sformatf("v%0d_exec", idx));
      push(adv_word(v.tmr, v.mux),      $sformatf("v%0d_advance", idx));
      push(quiet_word(v.mux),           $sformatf("v%0d_idle", idx));
      @(posedge clk); #1;
      @(posedge clk); #1;
      if (v.flip) begin
         Z_flag  = !v.z;
         PZ_flag = !v.pz;
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk); #1;
      exp_cnt++;
      chk($sformatf("v%0d_count", idx), int'(instr_count), exp_cnt);
      cur_mux  = v.mux;
      in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      tbl[0]  = '{4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 2'b01, S_ACC,  1'b1};
      tbl[1]  = '{4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 2'b10, S_ACC,  1'b1};
      tbl[2]  = '{4'd3,  1'b0, 1'b0, 1'b0, 1'b0, 2'b10, S_RAM,  1'b1};
      tbl[3]  = '{4'd4,  1'b0, 1'b0, 1'b0, 1'b0, 2'b11, S_ACC,  1'b1};
      tbl[4]  = '{4'd5,  1'b0, 1'b0, 1'b0, 1'b0, 2'b11, S_JMP,  1'b0};
      tbl[5]  = '{4'd6,  1'b1, 1'b0, 1'b0, 1'b0, 2'b11, S_ZJ,   1'b0};
      tbl[6]  = '{4'd6,  1'b0, 1'b0, 1'b0, 1'b0, 2'b11, S_ZJ,   1'b1};
      tbl[7]  = '{4'd7,  1'b0, 1'b1, 1'b0, 1'b0, 2'b11, S_PZJ,  1'b0};
      tbl[8]  = '{4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 2'b11, S_PZJ,  1'b1};
      tbl[9]  = '{4'd8,  1'b0, 1'b0, 1'b1, 1'b0, 2'b00, S_INP,  1'b1};
      tbl[10] = '{4'd9,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, S_OUT,  1'b1};
      tbl[11] = '{4'd12, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, S_NONE, 1'b1};
      tbl[12] = '{4'd6,  1'b0, 1'b1, 1'b0, 1'b0, 2'b00, S_ZJ,   1'b1};
      tbl[13] = '{4'd6,  1'b1, 1'b0, 1'b0, 1'b1, 2'b00, S_ZJ,   1'b0};
      tbl[14] = '{4'd7,  1'b0, 1'b0, 1'b0, 1'b1, 2'b00, S_PZJ,  1'b1};
      tbl[15] = '{4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, S_NONE, 1'b1};
      tbl[16] = '{4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 2'b01, S_ACC,  1'b1};
      tbl[17] = '{4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, S_NONE, 1'b1};
      tbl[18] = '{4'd2,  1'b1, 1'b1, 1'b0, 1'b0, 2'b10, S_ACC,  1'b1};

      reset = 1'b1; run = 1'b0; step = 1'b0; instr = 4'd0;
      Z_flag = 1'b0; PZ_flag = 1'b0; in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", int'(act_word()), 0);
      chk("reset_count", int'(instr_count), 0);
      chk("reset_count_sat", int'(instr_count2), 0);
      reset = 1'b0;

      // Free-run ADD twice; run drops during the second DECODE.
      instr = 4'd1;
      run   = 1'b1;
      @(posedge clk); #1;
      push(quiet_word(2'b00), "run_fetch1");
      push(quiet_word(2'b01), "run_decode1");
      push(exec_word(S_ACC, 2'b01), "run_exec1");
      push(adv_word(1'b1, 2'b01), "run_adv1");
      push(quiet_word(2'b01), "run_fetch2");
      push(quiet_word(2'b01), "run_decode2");
      push(exec_word(S_ACC, 2'b01), "run_exec2");
      push(adv_word(1'b1, 2'b01), "run_adv2");
      push(quiet_word(2'b01), "run_idle");
      repeat (5) @(posedge clk);
      #1;
      run = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      exp_cnt = 2;
      cur_mux = 2'b01;
      chk("run_count", int'(instr_count), exp_cnt);
      @(posedge clk); #1;

      for (int i = 0; i < 19; i++)
         do_vec(tbl[i], i);

      // INP stalls five cycles before the operand shows up.
      instr = 4'd8;
      step  = 1'b1;
      @(posedge clk); #1;
      step = 1'b0;
      push(quiet_word(cur_mux), "inp_fetch");
      push(quiet_word(2'b00), "inp_decode");
      for (int i = 0; i < 5; i++)
         push(quiet_word(2'b00), $sformatf("inp_wait%0d", i));
      push(exec_word(S_INP, 2'b00), "inp_accept");
      push(adv_word(1'b1, 2'b00), "inp_adv");
      push(quiet_word(2'b00), "inp_idle");
      repeat (7) @(posedge clk);
      #1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk); #1;
      exp_cnt++;
      cur_mux = 2'b00;
      chk("inp_count", int'(instr_count), exp_cnt);
      @(posedge clk); #1;

      // Reset lands while STA is in EXEC.
      instr = 4'd3;
      step  = 1'b1;
      @(posedge clk); #1;
      step = 1'b0;
      push(quiet_word(cur_mux), "sta_fetch");
      push(quiet_word(cur_mux), "sta_decode");
      push(exec_word(S_RAM, cur_mux), "sta_exec");
      push(quiet_word(2'b00), "sta_after_reset");
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk); #1;
      exp_cnt = 0;
      cur_mux = 2'b00;
      chk("sta_reset_count", int'(instr_count), 0);
      chk("sta_reset_count_sat", int'(instr_count2), 0);
      @(posedge clk); #1;

      // Single-stepped OUT; a stray step mid-instruction must not start another.
      instr = 4'd9;
      step  = 1'b1;
      @(posedge clk); #1;
      step = 1'b0;
      push(quiet_word(2'b00), "out_fetch");
      push(quiet_word(2'b00), "out_decode");
      push(exec_word(S_OUT, 2'b00), "out_exec");
      push(adv_word(1'b1, 2'b00), "out_adv");
      for (int i = 0; i < 3; i++)
         push(quiet_word(2'b00), $sformatf("out_idle%0d", i));
      @(posedge clk); #1;
      @(posedge clk); #1;
      step = 1'b1;
      @(posedge clk); #1;
      step = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      exp_cnt = 1;
      chk("out_count", int'(instr_count), exp_cnt);
      @(posedge clk); #1;

      // HLT under run: stuck in HALT, no strobes, count includes the HLT.
      instr = 4'd0;
      run   = 1'b1;
      @(posedge clk); #1;
      push(quiet_word(2'b00), "hlt_fetch");
      push(quiet_word(2'b00), "hlt_decode");
      for (int i = 0; i < 20; i++)
         push(W_HALT, $sformatf("hlt_%0d", i));
      repeat (21) @(posedge clk);
      @(negedge clk); #1;
      exp_cnt = 2;
      chk("hlt_count", int'(instr_count), exp_cnt);
      run = 1'b0;
      @(posedge clk); #1;

      // Five NOPs: the 2-bit counter saturates at 3, the 8-bit one reaches 5.
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      instr = 4'd12;
      run   = 1'b1;
      repeat (9) @(posedge clk);
      #1;
      chk("sat_mid_count", int'(instr_count2), 2);
      repeat (8) @(posedge clk);
      #1;
      run = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk); #1;
      chk("sat_count_wide", int'(instr_count), 5);
      chk("sat_count_narrow", int'(instr_count2), 3);

      repeat (2) @(posedge clk);
      #1;
      chk("scoreboard_drained", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
